// File: rtl/zeroskip_pkg.sv
// Shared sizing for the zero-skip partial-sum accumulator: default geometry,
// dot-product width and the row/accumulator types.
package zeroskip_pkg;

  localparam int M      = 32;
  localparam int ROWS   = 32;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;

  // Full-precision width of an M-term sum of DATA_W x DATA_W signed products.
  localparam int DOT_W  = 2 * DATA_W + $clog2(M);

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t [M-1:0]            row_vec_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [DOT_W-1:0]  dot_t;

  function automatic int dot_width(input int m, input int data_w);
    return 2 * data_w + $clog2(m);
  endfunction

endpackage

// File: rtl/zeroskip_dot_row.sv
// One row of the array: M signed multiplies reduced by a full-width adder
// tree. Purely combinational; the parent registers the result.
module zeroskip_dot_row #(
  parameter int M      = zeroskip_pkg::M,
  parameter int DATA_W = zeroskip_pkg::DATA_W,
  parameter int DOT_W  = zeroskip_pkg::dot_width(M, DATA_W)
) (
  input  logic [M*DATA_W-1:0] act,
  input  logic [M*DATA_W-1:0] wgt,
  output logic [DOT_W-1:0]    dot
);

  localparam int PROD_W = 2 * DATA_W;

  logic [M-1:0][DOT_W-1:0] prod;

  for (genvar gi = 0; gi < M; gi++) begin : g_mul
    logic signed [PROD_W-1:0] p;
    assign p        = $signed(act[gi*DATA_W +: DATA_W]) * $signed(wgt[gi*DATA_W +: DATA_W]);
    assign prod[gi] = DOT_W'(p);
  end

  // Products are sign-extended to DOT_W, so modular addition is exact.
  always_comb begin
    dot = '0;
    for (int i = 0; i < M; i++) begin
      dot = dot + prod[i];
    end
  end

endmodule

// File: rtl/zeroskip_psum_accum.sv
// Two-stage zero-skip accumulator: S1 registers per-row dot products, S2
// accumulates them with saturation and hands a finished group to the output.
module zeroskip_psum_accum #(
  parameter int M      = zeroskip_pkg::M,
  parameter int ROWS   = zeroskip_pkg::ROWS,
  parameter int DATA_W = zeroskip_pkg::DATA_W,
  parameter int ACC_W  = zeroskip_pkg::ACC_W
) (
  input  logic                       clk,
  input  logic                       a_rst_n,
  input  logic                       enable,
  input  logic [M*DATA_W*ROWS-1:0]   act_enc_din,
  input  logic                       act_enc_vld_i,
  input  logic                       act_enc_last_i,
  output logic                       act_enc_rdy_o,
  input  logic [M*DATA_W*ROWS-1:0]   wgt_din,
  input  logic                       wgt_vld_i,
  output logic                       wgt_rdy_o,
  output logic [ROWS*ACC_W-1:0]      psum_dout,
  output logic [ROWS-1:0]            psum_sat_o,
  output logic                       psum_vld_o,
  input  logic                       psum_rdy_i
);

  localparam int DOT_W = zeroskip_pkg::dot_width(M, DATA_W);
  localparam int SUM_W = ((ACC_W > DOT_W) ? ACC_W : DOT_W) + 1;
  localparam int ROW_W = M * DATA_W;

  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic                        s1_vld;
  logic                        s1_last;
  logic [ROWS-1:0][DOT_W-1:0]  s1_dot;
  logic [ROWS-1:0][DOT_W-1:0]  dot_comb;
  logic [ROWS-1:0][ACC_W-1:0]  acc;
  logic [ROWS-1:0][ACC_W-1:0]  acc_next;
  logic [ROWS-1:0]             sat_flag;
  logic [ROWS-1:0]             sat_next;
  logic                        first;

  logic s2_stall;
  logic s1_ready;
  logic s2_retire;
  logic fire;

  // A last beat cannot retire into an output register that is still held.
  assign s2_stall  = s1_vld & s1_last & psum_vld_o & ~psum_rdy_i;
  assign s1_ready  = ~s1_vld | ~s2_stall;
  assign s2_retire = s1_vld & ~s2_stall;

  assign act_enc_rdy_o = a_rst_n & wgt_vld_i & enable & s1_ready;
  assign wgt_rdy_o     = a_rst_n & act_enc_vld_i & enable & s1_ready;
  assign fire          = act_enc_vld_i & act_enc_rdy_o;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic signed [SUM_W-1:0] base;
    logic signed [SUM_W-1:0] sum;
    logic [ACC_W-1:0]        clamped;
    logic                    clip;

    zeroskip_dot_row #(
      .M      (M),
      .DATA_W (DATA_W),
      .DOT_W  (DOT_W)
    ) u_dot (
      .act (act_enc_din[gi*ROW_W +: ROW_W]),
      .wgt (wgt_din[gi*ROW_W +: ROW_W]),
      .dot (dot_comb[gi])
    );

    // First beat of a group starts from zero so a lone beat is still clamped.
    always_comb begin
      base    = first ? '0 : {{(SUM_W-ACC_W){acc[gi][ACC_W-1]}}, acc[gi]};
      sum     = base + {{(SUM_W-DOT_W){s1_dot[gi][DOT_W-1]}}, s1_dot[gi]};
      clamped = sum[ACC_W-1:0];
      clip    = 1'b0;
      if (sum > ACC_MAX) begin
        clamped = ACC_MAX[ACC_W-1:0];
        clip    = 1'b1;
      end else if (sum < ACC_MIN) begin
        clamped = ACC_MIN[ACC_W-1:0];
        clip    = 1'b1;
      end
    end

    assign acc_next[gi] = clamped;
    assign sat_next[gi] = (first ? 1'b0 : sat_flag[gi]) | clip;
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      s1_dot     <= '0;
      acc        <= '0;
      sat_flag   <= '0;
      first      <= 1'b1;
      psum_dout  <= '0;
      psum_sat_o <= '0;
      psum_vld_o <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_vld <= fire;
      end
      if (fire) begin
        s1_last <= act_enc_last_i;
        s1_dot  <= dot_comb;
      end
      if (s2_retire) begin
        acc      <= acc_next;
        sat_flag <= sat_next;
        first    <= s1_last;
      end
      if (s2_retire && s1_last) begin
        psum_dout  <= acc_next;
        psum_sat_o <= sat_next;
        psum_vld_o <= 1'b1;
      end else if (psum_rdy_i) begin
        psum_vld_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zeroskip_psum_accum.sv
// Scoreboard bench for zeroskip_psum_accum (ACC_W=16 so saturation is reachable):
// a behavioural model pushes expected groups on fire, the monitor pops on output.
module tb_zeroskip_psum_accum;

  localparam int M      = 32;
  localparam int ROWS   = 32;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int IN_W   = M * DATA_W * ROWS;
  localparam int OUT_W  = ROWS * ACC_W;
  localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACC_W - 1));

  logic             clk;
  logic             a_rst_n;
  logic             enable;
  logic [IN_W-1:0]  act_enc_din;
  logic             act_enc_vld_i;
  logic             act_enc_last_i;
  logic             act_enc_rdy_o;
  logic [IN_W-1:0]  wgt_din;
  logic             wgt_vld_i;
  logic             wgt_rdy_o;
  logic [OUT_W-1:0] psum_dout;
  logic [ROWS-1:0]  psum_sat_o;
  logic             psum_vld_o;
  logic             psum_rdy_i;

  zeroskip_psum_accum #(
    .M (M), .ROWS (ROWS), .DATA_W (DATA_W), .ACC_W (ACC_W)
  ) dut (
    .clk            (clk),
    .a_rst_n        (a_rst_n),
    .enable         (enable),
    .act_enc_din    (act_enc_din),
    .act_enc_vld_i  (act_enc_vld_i),
    .act_enc_last_i (act_enc_last_i),
    .act_enc_rdy_o  (act_enc_rdy_o),
    .wgt_din        (wgt_din),
    .wgt_vld_i      (wgt_vld_i),
    .wgt_rdy_o      (wgt_rdy_o),
    .psum_dout      (psum_dout),
    .psum_sat_o     (psum_sat_o),
    .psum_vld_o     (psum_vld_o),
    .psum_rdy_i     (psum_rdy_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [OUT_W-1:0] psum;
    logic [ROWS-1:0]  sat;
  } exp_t;

  exp_t          sb[$];
  longint        macc[ROWS];
  bit [ROWS-1:0] msat;
  bit            mfirst = 1'b1;
  bit            rdy_rand = 1'b0;

  function automatic logic [IN_W-1:0] fill(input logic [DATA_W-1:0] v);
    logic [IN_W-1:0] f;
    for (int i = 0; i < M * ROWS; i++) f[i*DATA_W +: DATA_W] = v;
    return f;
  endfunction

  function automatic logic [IN_W-1:0] rnd_vec();
    logic [IN_W-1:0] f;
    for (int i = 0; i < M * ROWS; i++) f[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return f;
  endfunction

  // Reference: integer dot per row, clamp after every beat, sticky flag per group.
  task automatic model_fire(input logic [IN_W-1:0] a, input logic [IN_W-1:0] w, input bit last);
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      longint d = 0;
      longint s;
      bit     cl = 1'b0;
      for (int k = 0; k < M; k++) begin
        d += longint'($signed(a[(r*M+k)*DATA_W +: DATA_W])) * longint'($signed(w[(r*M+k)*DATA_W +: DATA_W]));
      end
      s = (mfirst ? 0 : macc[r]) + d;
      if (s > AMAX) begin s = AMAX; cl = 1'b1; end
      else if (s < AMIN) begin s = AMIN; cl = 1'b1; end
      macc[r] = s;
      msat[r] = (mfirst ? 1'b0 : msat[r]) | cl;
      e.psum[r*ACC_W +: ACC_W] = ACC_W'(s);
    end
    e.sat  = msat;
    mfirst = last;
    if (last) sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat fired.
  task automatic send_beat(input logic [IN_W-1:0] a, input logic [IN_W-1:0] w,
                           input bit last, input bit rand_w);
    bit fired = 1'b0;
    int n = 0;
    act_enc_din    = a;
    wgt_din        = w;
    act_enc_last_i = last;
    act_enc_vld_i  = 1'b1;
    while (!fired && n < 200) begin
      wgt_vld_i = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!wgt_vld_i) expect_eq("act_rdy_without_wgt_vld", act_enc_rdy_o, 0);
      fired = act_enc_vld_i & wgt_vld_i & act_enc_rdy_o & wgt_rdy_o;
      @(posedge clk);
      if (fired) model_fire(a, w, last);
      @(negedge clk);
      n++;
    end
    if (!fired) expect_eq("fire_timeout", fired, 1);
    act_enc_vld_i = 1'b0;
    wgt_vld_i     = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_rand) psum_rdy_i = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: pop on every accepted result, and check holds under stall.
  initial begin
    logic [OUT_W-1:0] prev_psum;
    bit   prev_hold = 1'b0;
    int   ntx = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!a_rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          expect_eq("hold_psum", psum_dout, prev_psum);
          expect_eq("hold_vld", psum_vld_o, 1);
        end
        if (psum_vld_o && psum_rdy_i) begin
          if (sb.size() == 0) begin
            expect_eq("unexpected_psum", psum_vld_o, 0);
          end else begin
            e = sb.pop_front();
            expect_eq("psum", psum_dout, e.psum);
            expect_eq("psum_sat", psum_sat_o, e.sat);
            $display("txn %0d: row0=%0d rowN=%0d sat=%h", ntx,
                     $signed(psum_dout[ACC_W-1:0]), $signed(psum_dout[OUT_W-1 -: ACC_W]), psum_sat_o);
            ntx++;
          end
        end
        prev_hold = psum_vld_o && !psum_rdy_i;
        prev_psum = psum_dout;
      end
    end
  end

  initial begin
    a_rst_n        = 1'b0;
    enable         = 1'b1;
    act_enc_din    = '0;
    wgt_din        = '0;
    act_enc_vld_i  = 1'b1;
    act_enc_last_i = 1'b0;
    wgt_vld_i      = 1'b1;
    psum_rdy_i     = 1'b1;

    // Reset state, with both valids high to see ready held low.
    repeat (3) @(negedge clk);
    expect_eq("rst_vld", psum_vld_o, 0);
    expect_eq("rst_psum", psum_dout, 0);
    expect_eq("rst_sat", psum_sat_o, 0);
    expect_eq("rst_act_rdy", act_enc_rdy_o, 0);
    expect_eq("rst_wgt_rdy", wgt_rdy_o, 0);
    act_enc_vld_i = 1'b0;
    wgt_vld_i     = 1'b0;
    a_rst_n       = 1'b1;
    repeat (2) @(negedge clk);

    // Single-beat group: 1*2*32 = 64 per row, result two edges after fire.
    send_beat(fill(8'h01), fill(8'h02), 1'b1, 1'b0);
    expect_eq("lat_edge1_vld", psum_vld_o, 0);
    @(negedge clk);
    expect_eq("lat_edge2_vld", psum_vld_o, 1);
    expect_eq("single_beat_row0", psum_dout[ACC_W-1:0], 64);
    repeat (3) @(negedge clk);

    // Saturation: 3 x 516128 clamps to 32767 with every flag set.
    for (int b = 0; b < 3; b++) send_beat(fill(8'h7F), fill(8'h7F), b == 2, 1'b0);
    repeat (4) @(negedge clk);

    // 4-beat group: -3*5*32*4 = -1920, flags clear again.
    for (int b = 0; b < 4; b++) send_beat(fill(8'hFD), fill(8'h05), b == 3, 1'b0);
    repeat (4) @(negedge clk);

    // Backpressure: result A held, B stalls in S1, C must see ready low.
    psum_rdy_i = 1'b0;
    send_beat(fill(8'h01), fill(8'h03), 1'b1, 1'b0);
    send_beat(fill(8'h02), fill(8'h03), 1'b1, 1'b0);
    act_enc_din    = fill(8'h04);
    wgt_din        = fill(8'h03);
    act_enc_last_i = 1'b1;
    act_enc_vld_i  = 1'b1;
    wgt_vld_i      = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      expect_eq("bp_act_rdy", act_enc_rdy_o, 0);
      expect_eq("bp_wgt_rdy", wgt_rdy_o, 0);
      @(negedge clk);
    end
    psum_rdy_i = 1'b1;
    send_beat(fill(8'h04), fill(8'h03), 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    // enable low blocks acceptance.
    enable        = 1'b0;
    act_enc_vld_i = 1'b1;
    wgt_vld_i     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      expect_eq("dis_act_rdy", act_enc_rdy_o, 0);
      expect_eq("dis_wgt_rdy", wgt_rdy_o, 0);
      @(negedge clk);
    end
    enable = 1'b1;
    send_beat(fill(8'h03), fill(8'hFE), 1'b1, 1'b0);

    // Weight valid toggling with activation valid held high, random data.
    for (int g = 0; g < 3; g++) begin
      int len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) send_beat(rnd_vec(), rnd_vec(), b == len - 1, 1'b1);
    end

    // Random data, random lengths, random output backpressure.
    rdy_rand = 1'b1;
    for (int g = 0; g < 5; g++) begin
      int len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) send_beat(rnd_vec(), rnd_vec(), b == len - 1, 1'b0);
    end
    rdy_rand   = 1'b0;
    psum_rdy_i = 1'b1;
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
    expect_eq("drain_before_reset", sb.size(), 0);

    // Reset after 2 of 4 beats: nothing emitted, next 1-beat group is fresh.
    send_beat(fill(8'h05), fill(8'h07), 1'b0, 1'b0);
    send_beat(fill(8'h05), fill(8'h07), 1'b0, 1'b0);
    act_enc_vld_i = 1'b1;
    wgt_vld_i     = 1'b1;
    #2;
    a_rst_n = 1'b0;
    #1;
    expect_eq("midrst_act_rdy", act_enc_rdy_o, 0);
    expect_eq("midrst_wgt_rdy", wgt_rdy_o, 0);
    expect_eq("midrst_vld", psum_vld_o, 0);
    @(negedge clk);
    a_rst_n       = 1'b1;
    act_enc_vld_i = 1'b0;
    wgt_vld_i     = 1'b0;
    mfirst        = 1'b1;
    repeat (6) @(negedge clk);
    send_beat(fill(8'h01), fill(8'hFF), 1'b1, 1'b0);

    for (int c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    expect_eq("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
